// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD card command sender and response
// receiver: receiver state encoding, response lengths, R1 status bit
// positions and the command framing / CRC7 constants used on MOSI.
package sd_pkg;

    // Response receiver states
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        FIN
    } recv_state_e;

    // Response lengths and the N_CR start-bit search window
    localparam int SD_R1_BITS  = 8;
    localparam int SD_R37_BITS = 40;
    localparam int SD_NCR_MAX  = 80;

    // R1 status bit positions
    localparam int R1_BIT_IDLE        = 0;
    localparam int R1_BIT_ILLEGAL_CMD = 2;
    localparam int R1_BIT_CRC_ERR     = 3;

    // Command frame layout: 01 + 6-bit index + 32-bit argument + CRC7 + 1
    localparam int         SD_CMD_BITS   = 48;
    localparam logic [1:0] SD_CMD_START  = 2'b01;
    localparam logic       SD_CMD_STOP   = 1'b1;
    localparam logic [6:0] SD_CMD0_CRC7  = 7'h4A;
    localparam logic [6:0] SD_CMD8_CRC7  = 7'h43;
    localparam logic [6:0] SD_CRC7_POLY  = 7'h09;

    // One serial step of the CRC7 (x^7 + x^3 + 1) used on command frames
    function automatic logic [6:0] crc7Step(input logic [6:0] crc, input logic dataBit);
        logic feedback;
        feedback = crc[6] ^ dataBit;
        return {crc[5:0], 1'b0} ^ (feedback ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/recv_sd.sv
// SPI-mode SD card response receiver. After the controller pulses start, it
// hunts for the response start bit on SDin within an N_CR window, then shifts
// in an 8-bit R1 or 40-bit R3/R7 response MSB first and pulses done, or
// pulses timeout with an all-ones response if the card never answers.
module recv_sd
    import sd_pkg::*;
#(
    parameter int NCR_MAX    = SD_NCR_MAX,
    parameter int LONG_BITS  = SD_R37_BITS,
    parameter int SHORT_BITS = SD_R1_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  long,
    input  logic                  SDin,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [LONG_BITS-1:0]  response,
    output logic [SHORT_BITS-1:0] r1
);

    // The single counter is the wait counter in WAIT and the bit counter in
    // SHIFT. The start bit is consumed in WAIT, so SHIFT starts at length-2.
    localparam logic [6:0] NCR_LAST   = 7'(NCR_MAX - 1);
    localparam logic [6:0] LOAD_LONG  = 7'(LONG_BITS - 2);
    localparam logic [6:0] LOAD_SHORT = 7'(SHORT_BITS - 2);
    localparam logic [6:0] R1_AT_LONG = 7'(LONG_BITS - SHORT_BITS);

    recv_state_e           state_q, state_d;
    logic                  longSel_q, longSel_d;
    logic                  timedOut_q, timedOut_d;
    logic [6:0]            cnt_q, cnt_d;
    logic [LONG_BITS-1:0]  response_q, response_d;
    logic [SHORT_BITS-1:0] r1_q, r1_d;
    logic [6:0]            r1Point;

    // State register; reset aborts any transfer without a done/timeout pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a 0 on SDin in WAIT is the R1 MSB and starts the shift
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = WAIT;
            WAIT:    if (!SDin) state_d = SHIFT;
                     else if (cnt_q == NCR_LAST) state_d = FIN;
            SHIFT:   if (cnt_q == 7'd0) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; FIN carries either done or timeout, never both
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            WAIT, SHIFT: busy = 1'b1;
            FIN: begin
                done    = !timedOut_q;
                timeout = timedOut_q;
            end
            default: ;
        endcase
    end

    // The R1 byte is complete when the eighth received bit shifts in
    assign r1Point = longSel_q ? R1_AT_LONG : 7'd0;

    // Datapath next-state: length latch, counter, shift register and R1 capture
    always_comb begin
        longSel_d  = longSel_q;
        timedOut_d = timedOut_q;
        cnt_d      = cnt_q;
        response_d = response_q;
        r1_d       = r1_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    longSel_d  = long;
                    timedOut_d = 1'b0;
                    cnt_d      = 7'd0;
                end
            end
            WAIT: begin
                if (!SDin) begin
                    response_d = '0;
                    cnt_d      = longSel_q ? LOAD_LONG : LOAD_SHORT;
                end else if (cnt_q == NCR_LAST) begin
                    timedOut_d = 1'b1;
                    response_d = longSel_q ? '1
                                           : {{(LONG_BITS-SHORT_BITS){1'b0}}, {SHORT_BITS{1'b1}}};
                    r1_d       = '1;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            SHIFT: begin
                response_d = {response_q[LONG_BITS-2:0], SDin};
                if (cnt_q == r1Point) begin
                    r1_d = {response_q[SHORT_BITS-2:0], SDin};
                end
                if (cnt_q != 7'd0) begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            FIN: begin
                cnt_d = 7'd0;
            end
            default: ;
        endcase
    end

    // Datapath registers; response and r1 hold between transfers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            longSel_q  <= 1'b0;
            timedOut_q <= 1'b0;
            cnt_q      <= 7'd0;
            response_q <= '0;
            r1_q       <= '0;
        end else begin
            longSel_q  <= longSel_d;
            timedOut_q <= timedOut_d;
            cnt_q      <= cnt_d;
            response_q <= response_d;
            r1_q       <= r1_d;
        end
    end

    assign response = response_q;
    assign r1       = r1_q;

endmodule

// File: tb/tb_recv_sd.sv
// Scoreboard bench for recv_sd: the driver pushes the hand-computed result
// of each response it plays onto a queue, and a monitor pops and compares it
// whenever done or timeout pulses, including latency and busy duration.
module tb_recv_sd;

    typedef struct {
        bit          isTimeout;
        logic [39:0] resp;
        logic [7:0]  r1;
        int          latency;
        int          startCyc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic        long;
    logic        SDin;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [39:0] response;
    logic [7:0]  r1;

    exp_t expQ[$];
    int   cyc;
    int   busyRun;
    int   checkCount;
    int   passCount;

    recv_sd dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .long     (long),
        .SDin     (SDin),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .response (response),
        .r1       (r1)
    );

    // Free-running clock and cycle index used to measure latency
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count a comparison and report it when the value is wrong
    task automatic checkOutput(input string name, input logic [39:0] actual, input logic [39:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input bit isTimeout, input logic [39:0] resp,
                                   input logic [7:0] r1v, input int latency);
        exp_t e;
        e.isTimeout = isTimeout;
        e.resp      = resp;
        e.r1        = r1v;
        e.latency   = latency;
        e.startCyc  = 0;
        return e;
    endfunction

    // Pulse start, hold SDin high for preOnes clocks, then play nbits of
    // bits MSB first; start is pulsed again at bit index extraStartAt.
    // Returns in the FIN cycle with SDin idle.
    task automatic applyStimulus(input bit isLong, input int preOnes, input logic [39:0] bits,
                                 input int nbits, input int extraStartAt, input exp_t e);
        @(posedge clock); #2;
        start = 1'b1;
        long  = isLong;
        SDin  = 1'b1;
        e.startCyc = cyc;
        expQ.push_back(e);
        for (int i = 0; i < preOnes; i++) begin
            @(posedge clock); #2;
            start = 1'b0;
            SDin  = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            @(posedge clock); #2;
            start = (i == extraStartAt);
            SDin  = bits[nbits-1-i];
        end
        @(posedge clock); #2;
        start = 1'b0;
        SDin  = 1'b1;
    endtask

    // Monitor: pop and compare on every done/timeout pulse
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            busyRun = 0;
        end else if (done || timeout) begin
            checkOutput("exclusive", {39'd0, done & timeout}, 40'd0);
            checkOutput("busyAtPulse", {39'd0, busy}, 40'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedPulse", {39'd0, done}, {39'd0, 1'b0 ^ done ^ 1'b1});
            end else begin
                e = expQ.pop_front();
                checkOutput("kindTimeout", {39'd0, timeout}, {39'd0, e.isTimeout});
                checkOutput("response", response, e.resp);
                checkOutput("r1", {32'd0, r1}, {32'd0, e.r1});
                checkOutput("latency", 40'(cyc - e.startCyc), 40'(e.latency));
                checkOutput("busyCycles", 40'(busyRun), 40'(e.latency - 1));
            end
            busyRun = 0;
        end else if (busy) begin
            busyRun++;
        end
    end

    initial begin
        checkCount = 0;
        passCount  = 0;
        busyRun    = 0;
        reset      = 1'b0;
        start      = 1'b0;
        long       = 1'b0;
        SDin       = 1'b1;

        $display("[TB] reset state");
        repeat (2) @(posedge clock);
        #2;
        checkOutput("rstBusy", {39'd0, busy}, 40'd0);
        checkOutput("rstDone", {39'd0, done}, 40'd0);
        checkOutput("rstTimeout", {39'd0, timeout}, 40'd0);
        checkOutput("rstResponse", response, 40'd0);
        checkOutput("rstR1", {32'd0, r1}, 40'd0);
        reset = 1'b1;

        $display("[TB] short response, start bit immediately");
        applyStimulus(1'b0, 0, 40'h01, 8, -1, mkExp(1'b0, 40'h01, 8'h01, 9));

        $display("[TB] long response after five idle bits");
        applyStimulus(1'b1, 5, 40'h01000001AA, 40, -1, mkExp(1'b0, 40'h01000001AA, 8'h01, 46));

        $display("[TB] no start bit, long timeout");
        applyStimulus(1'b1, 85, 40'h0, 0, -1, mkExp(1'b1, 40'hFFFFFFFFFF, 8'hFF, 81));

        $display("[TB] start pulsed while shifting");
        applyStimulus(1'b0, 0, 40'h3C, 8, 4, mkExp(1'b0, 40'h3C, 8'h3C, 9));
        repeat (3) @(posedge clock);

        $display("[TB] back-to-back responses");
        applyStimulus(1'b0, 0, 40'h04, 8, -1, mkExp(1'b0, 40'h04, 8'h04, 9));
        applyStimulus(1'b0, 0, 40'h05, 8, -1, mkExp(1'b0, 40'h05, 8'h05, 9));

        $display("[TB] reset during shift");
        @(posedge clock); #2;
        start = 1'b1;
        long  = 1'b1;
        SDin  = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
        SDin  = 1'b0;
        @(posedge clock); #2;
        SDin  = 1'b0;
        @(posedge clock); #2;
        SDin  = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        checkOutput("abortBusy", {39'd0, busy}, 40'd0);
        checkOutput("abortDone", {39'd0, done}, 40'd0);
        checkOutput("abortTimeout", {39'd0, timeout}, 40'd0);
        checkOutput("abortResponse", response, 40'd0);
        checkOutput("abortR1", {32'd0, r1}, 40'd0);
        @(posedge clock); #2;
        reset = 1'b1;
        SDin  = 1'b1;
        applyStimulus(1'b0, 2, 40'h09, 8, -1, mkExp(1'b0, 40'h09, 8'h09, 11));

        for (int i = 0; i < 100 && expQ.size() != 0; i++) begin
            @(posedge clock);
        end
        repeat (5) @(posedge clock);
        checkOutput("pendingResponses", 40'(expQ.size()), 40'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
